// File: rtl/uart_tx_fifo_cfg.sv
// ============================================================================
// Module   : uart_tx_fifo_cfg
// Purpose  : UART transmitter with a parametrised input FIFO and per-frame
//            configuration of data length (5..DATA_WIDTH), parity and stop
//            bits. Frames are streamed back-to-back while the FIFO holds
//            data. Bit timing comes from an external baud tick strobe,
//            OVERSAMPLE ticks per bit.
// Optional : `define UART_TX_BREAK_EN adds a TX_BREAK input and a BREAK
//            state that holds the line low for a break condition.
// Ports    :
//   CLK            in   system clock
//   RESET          in   asynchronous active-high reset
//   TX_BR_TICKS    in   baud tick strobe, one CLK cycle wide
//   CFG_DATA_BITS  in   data bits per frame (clamped to 5..DATA_WIDTH)
//   CFG_PARITY_EN  in   insert parity bit
//   CFG_PARITY_ODD in   1 = odd parity, 0 = even parity
//   CFG_STOP2      in   1 = two stop bits
//   TX_BREAK       in   break request (UART_TX_BREAK_EN builds only)
//   TX_VALID       in   push request
//   TX_READY       out  FIFO not full
//   TX_DATA_IN     in   word to send, LSB first
//   TX             out  serial line, idles high
//   TX_BUSY        out  high while the FSM is not in IDLE
//   TX_DONE        out  one-cycle pulse at the end of each frame
//   FIFO_COUNT     out  current FIFO occupancy
//   STATE_DBG      out  current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        TX_BR_TICKS,
    input  logic [3:0]                  CFG_DATA_BITS,
    input  logic                        CFG_PARITY_EN,
    input  logic                        CFG_PARITY_ODD,
    input  logic                        CFG_STOP2,
`ifdef UART_TX_BREAK_EN
    input  logic                        TX_BREAK,
`endif
    input  logic                        TX_VALID,
    output logic                        TX_READY,
    input  logic [DATA_WIDTH-1:0]       TX_DATA_IN,
    output logic                        TX,
    output logic                        TX_BUSY,
    output logic                        TX_DONE,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
    output logic [2:0]                  STATE_DBG
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam int TICK_W = $clog2(2 * OVERSAMPLE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
    localparam int         BRK_W    = $clog2((DATA_WIDTH + 3) * OVERSAMPLE + 1);
    localparam logic [BRK_W-1:0] BRK_MIN = BRK_W'((DATA_WIDTH + 3) * OVERSAMPLE);
`endif

    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST = TICK_W'(2 * OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]        DW_C       = 4'(DATA_WIDTH);

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign push = TX_VALID && TX_READY;
    assign head = mem[rd_ptr];

    // Storage needs no reset: contents are only read when count says valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= TX_DATA_IN;
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    assign FIFO_COUNT = count;

    // ------------------------------------------------------------------
    // Frame configuration decode, evaluated against the FIFO head so it
    // can be latched on the pop edge.
    // ------------------------------------------------------------------
    logic [3:0]            len_clamp;
    logic [IDX_W-1:0]      len_last;
    logic [DATA_WIDTH-1:0] len_mask;
    logic                  head_par;

    always_comb begin
        if (CFG_DATA_BITS < 4'd5) begin
            len_clamp = 4'd5;
        end else if (CFG_DATA_BITS > DW_C) begin
            len_clamp = DW_C;
        end else begin
            len_clamp = CFG_DATA_BITS;
        end
        len_last = IDX_W'(len_clamp - 4'd1);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            len_mask[i] = (i < int'(len_clamp));
        end
        // Parity covers only the bits that will actually be shifted out.
        head_par = (^(head & len_mask)) ^ CFG_PARITY_ODD;
    end

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    logic [2:0]            state,     state_nxt;
    logic [TICK_W-1:0]     tick_cnt,  tick_cnt_nxt;
    logic [IDX_W-1:0]      bit_idx,   bit_idx_nxt;
    logic [IDX_W-1:0]      data_last, data_last_nxt;
    logic [DATA_WIDTH-1:0] shreg,     shreg_nxt;
    logic                  par_bit,   par_bit_nxt;
    logic                  par_en_l,  par_en_l_nxt;
    logic                  stop2_l,   stop2_l_nxt;
`ifdef UART_TX_BREAK_EN
    logic [BRK_W-1:0]      brk_cnt,   brk_cnt_nxt;
    logic                  brk_mark,  brk_mark_nxt;
`endif
    logic                  tick_clr;
    logic                  frame_end;
    logic                  bit_end;
    logic                  stop_end;

    assign bit_end  = TX_BR_TICKS && (tick_cnt == BIT_LAST);
    assign stop_end = TX_BR_TICKS && (tick_cnt == (stop2_l ? STOP2_LAST : BIT_LAST));

    // State register (with the datapath it sequences)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            data_last <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_en_l  <= 1'b0;
            stop2_l   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt   <= '0;
            brk_mark  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            data_last <= data_last_nxt;
            shreg     <= shreg_nxt;
            par_bit   <= par_bit_nxt;
            par_en_l  <= par_en_l_nxt;
            stop2_l   <= stop2_l_nxt;
`ifdef UART_TX_BREAK_EN
            brk_cnt   <= brk_cnt_nxt;
            brk_mark  <= brk_mark_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        bit_idx_nxt   = bit_idx;
        data_last_nxt = data_last;
        shreg_nxt     = shreg;
        par_bit_nxt   = par_bit;
        par_en_l_nxt  = par_en_l;
        stop2_l_nxt   = stop2_l;
`ifdef UART_TX_BREAK_EN
        brk_cnt_nxt   = brk_cnt;
        brk_mark_nxt  = brk_mark;
`endif
        pop           = 1'b0;
        frame_end     = 1'b0;
        tick_clr      = 1'b0;

        case (state)
            S_IDLE: begin
                tick_clr = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (TX_BREAK) begin
                    state_nxt    = S_BREAK;
                    brk_cnt_nxt  = '0;
                    brk_mark_nxt = 1'b0;
                end else
`endif
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tick_clr  = 1'b1;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tick_clr = 1'b1;
                    if (bit_idx == data_last) begin
                        state_nxt = par_en_l ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        shreg_nxt   = shreg >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tick_clr  = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    tick_clr  = 1'b1;
                    frame_end = 1'b1;
                    // Chain straight into the next frame when data waits.
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (!brk_mark) begin
                    // Low phase: count ticks up to the minimum, then wait
                    // for release before the closing mark period.
                    tick_clr = 1'b1;
                    if (TX_BR_TICKS && (brk_cnt != BRK_MIN)) begin
                        brk_cnt_nxt = brk_cnt + BRK_W'(1);
                    end
                    if ((brk_cnt == BRK_MIN) && !TX_BREAK) begin
                        brk_mark_nxt = 1'b1;
                    end
                end else if (bit_end) begin
                    tick_clr  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                tick_clr  = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase

        if (pop) begin
            shreg_nxt     = head;
            data_last_nxt = len_last;
            par_bit_nxt   = head_par;
            par_en_l_nxt  = CFG_PARITY_EN;
            stop2_l_nxt   = CFG_STOP2;
            bit_idx_nxt   = '0;
        end

        if (tick_clr) begin
            tick_cnt_nxt = '0;
        end else if (TX_BR_TICKS) begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
        end else begin
            tick_cnt_nxt = tick_cnt;
        end
    end

    // Output logic: values for the output registers, derived from the
    // state being entered so TX changes on the same edge as the state.
    logic tx_nxt;
    logic busy_nxt;
    logic ready_nxt;

    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shreg_nxt[0];
            S_PARITY: tx_nxt = par_bit_nxt;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_nxt = brk_mark_nxt;
`endif
            default:  tx_nxt = 1'b1;
        endcase
        busy_nxt  = (state_nxt != S_IDLE);
        ready_nxt = (count_nxt != DEPTH_C);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TX       <= 1'b1;
            TX_BUSY  <= 1'b0;
            TX_DONE  <= 1'b0;
            TX_READY <= 1'b1;
        end else begin
            TX       <= tx_nxt;
            TX_BUSY  <= busy_nxt;
            TX_DONE  <= frame_end;
            TX_READY <= ready_nxt;
        end
    end

    assign STATE_DBG = state;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_cfg.sv
// ============================================================================
// Module   : tb_uart_tx_fifo_cfg
// Purpose  : Self-checking bench for uart_tx_fifo_cfg. Pushed words queue an
//            expected frame description; a line monitor decodes TX in baud
//            ticks and compares each frame against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo_cfg;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       br_tick = 1'b0;
    logic [3:0] cfg_bits = 4'd8;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       stop2 = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    uart_tx_fifo_cfg #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .TX_BR_TICKS    (br_tick),
        .CFG_DATA_BITS  (cfg_bits),
        .CFG_PARITY_EN  (par_en),
        .CFG_PARITY_ODD (par_odd),
        .CFG_STOP2      (stop2),
`ifdef UART_TX_BREAK_EN
        .TX_BREAK       (1'b0),
`endif
        .TX_VALID       (tx_valid),
        .TX_READY       (tx_ready),
        .TX_DATA_IN     (tx_data),
        .TX             (tx),
        .TX_BUSY        (tx_busy),
        .TX_DONE        (tx_done),
        .FIFO_COUNT     (fifo_count),
        .STATE_DBG      (state_dbg)
    );

    typedef struct {
        logic [7:0] data;   // data bits expected on the line (already masked)
        int         nbits;  // data bits expected after clamping
        bit         pe;     // parity bit present
        bit         pv;     // expected parity bit value
        bit         s2;     // two stop bits
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic set_cfg(input logic [3:0] b, input logic pe, input logic po, input logic s2);
        cfg_bits = b;
        par_en   = pe;
        par_odd  = po;
        stop2    = s2;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d, input logic [7:0] ed, input int nb,
                        input bit pe, input bit pv, input bit s2, output int waited);
        frame_t f;
        tx_data  = d;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            timeout_fail("push");
            tx_valid = 1'b0;
        end else begin
            f.data = ed; f.nbits = nb; f.pe = pe; f.pv = pv; f.s2 = s2;
            sb.push_back(f);
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state_dbg !== s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (state_dbg !== s) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || state_dbg !== 3'd0 || tx_busy !== 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout_fail(name);
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Line monitor: decodes frames in tick units and checks against sb.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit         at_edge;
        frame_t     f;
        logic [10:0] bv;
        int         nb, tt, cyc, steps, fidx;
        bit         aborted, stop_ok, early;
        logic       tk;
        at_edge = 1'b0;
        fidx    = 0;
        forever begin
            if (!at_edge) @(negedge clk);
            at_edge = 1'b0;
            if (rst || tx !== 1'b0) continue;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: start bit with no frame expected (frames seen %0d)", fidx);
                while (tx === 1'b0 && !rst) @(negedge clk);
                continue;
            end
            f  = sb.pop_front();
            nb = 1 + f.nbits + (f.pe ? 1 : 0);
            bv = '1;
            bv[0] = 1'b0;
            for (int i = 0; i < f.nbits; i++) bv[1 + i] = f.data[i];
            if (f.pe) bv[1 + f.nbits] = f.pv;
            tt = OS * nb + (f.s2 ? 2 * OS : OS);
            cyc = 0; steps = 0; aborted = 1'b0; stop_ok = 1'b1; early = 1'b0;
            while (cyc < tt && steps < 4000) begin
                @(posedge clk);
                tk = br_tick;
                @(negedge clk);
                steps++;
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (tk) cyc++;
                if (cyc < tt) begin
                    if (tx_done) early = 1'b1;
                    if (tk && (cyc % OS) == OS / 2 && cyc < OS * nb)
                        check($sformatf("frame%0d_bit%0d", fidx, cyc / OS), 32'(tx), 32'(bv[cyc / OS]));
                    if (cyc >= OS * nb && tx !== 1'b1) stop_ok = 1'b0;
                end
            end
            if (aborted) begin
                while (rst) @(negedge clk);
                fidx++;
                continue;
            end
            if (cyc < tt) begin
                timeout_fail($sformatf("frame%0d_end", fidx));
            end else begin
                check($sformatf("frame%0d_done_at_%0d_ticks", fidx, tt), 32'(tx_done), 32'd1);
                check($sformatf("frame%0d_no_early_done", fidx), 32'(early), 32'd0);
                check($sformatf("frame%0d_stop_high", fidx), 32'(stop_ok), 32'd1);
                check($sformatf("frame%0d_busy_at_end", fidx), 32'(tx_busy), 32'(sb.size() != 0));
                if (sb.size() != 0)
                    check($sformatf("frame%0d_back_to_back_start", fidx), 32'(tx), 32'd0);
            end
            at_edge = 1'b1;
            fidx++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int w;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 0xA5, 8N1
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        br_tick = 1'b1;
        push(8'hA5, 8'hA5, 8, 1'b0, 1'b0, 1'b0, w);
        wait_idle("t1_idle");

        // 2: 0x35, 7 bits, even then odd parity, 2 stop bits
        set_cfg(4'd7, 1'b1, 1'b0, 1'b1);
        push(8'h35, 8'h35, 7, 1'b1, 1'b0, 1'b1, w);
        wait_state(3'd1, "t2_start");
        par_odd = 1'b1;
        push(8'h35, 8'h35, 7, 1'b1, 1'b1, 1'b1, w);
        wait_idle("t2_idle");

        // 3: fill FIFO with ticks stalled
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        br_tick = 1'b0;
        push(8'h11, 8'h11, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'h22, 8'h22, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'h33, 8'h33, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'h44, 8'h44, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'h55, 8'h55, 8, 1'b0, 1'b0, 1'b0, w);
        check("t3_count_full", 32'(fifo_count), 32'd4);
        check("t3_ready_low", 32'(tx_ready), 32'd0);
        check("t3_state_start", 32'(state_dbg), 32'd1);
        check("t3_tx_start_low", 32'(tx), 32'd0);
        br_tick = 1'b1;
        push(8'h66, 8'h66, 8, 1'b0, 1'b0, 1'b0, w);
        check("t3_sixth_wait_cycles", 32'(w), 32'd160);
        wait_idle("t3_idle");

        // 4: 0x00 then 0xFF back-to-back
        push(8'h00, 8'h00, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'hFF, 8'hFF, 8, 1'b0, 1'b0, 1'b0, w);
        wait_idle("t4_idle");

        // 5: reset while in DATA with two words queued
        push(8'h5A, 8'h5A, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'hC3, 8'hC3, 8, 1'b0, 1'b0, 1'b0, w);
        push(8'h7E, 8'h7E, 8, 1'b0, 1'b0, 1'b0, w);
        wait_state(3'd2, "t5_data");
        #2 rst = 1'b1;
        #1;
        check("t5_tx_high", 32'(tx), 32'd1);
        check("t5_busy_low", 32'(tx_busy), 32'd0);
        check("t5_count_zero", 32'(fifo_count), 32'd0);
        check("t5_ready_high", 32'(tx_ready), 32'd1);
        check("t5_state_idle", 32'(state_dbg), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push(8'h96, 8'h96, 8, 1'b0, 1'b0, 1'b0, w);
        wait_idle("t5_idle");

        // 6: length clamp to 5 and mid-frame parity enable
        set_cfg(4'd3, 1'b0, 1'b0, 1'b0);
        push(8'hF3, 8'h13, 5, 1'b0, 1'b0, 1'b0, w);
        push(8'h0E, 8'h0E, 5, 1'b1, 1'b1, 1'b0, w);
        wait_state(3'd2, "t6_data");
        par_en = 1'b1;
        wait_idle("t6_idle");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
